// File: rtl/spi_display_receiver_pkg.sv
// Shared definitions for the SPI display receiver.
// Holds the register address map, the FSM state encoding and the frame
// geometry so the top level and any tooling agree on one set of values.
package spi_display_receiver_pkg;

  // Register address map (frame bits [11:8])
  localparam logic [3:0] ADDR_NOOP       = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0     = 4'h1;
  localparam logic [3:0] ADDR_DIGIT7     = 4'h8;
  localparam logic [3:0] ADDR_DECODE     = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY  = 4'hA;
  localparam logic [3:0] ADDR_SCAN_LIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN   = 4'hC;
  localparam logic [3:0] ADDR_TEST       = 4'hF;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RECV   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Frame geometry; the bit counter saturates one past a legal frame so any
  // overlong frame stays distinguishable from a legal one.
  localparam logic [4:0] FRAME_BITS = 5'd16;
  localparam logic [4:0] CNT_SAT    = 5'd17;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer with one trailing history flop for edge detection.
// Ports:
//   clk, rst_n : clock and async active-low reset
//   din        : asynchronous input pin
//   dout       : synchronized level
//   dout_prev  : synchronized level delayed by one clk (edge detection)
module spi_input_sync #(
  parameter int       DEPTH   = 2,
  parameter bit       RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic dout_prev
);

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain     <= {DEPTH{RST_VAL}};
      dout_prev <= RST_VAL;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
      dout_prev <= chain[DEPTH-1];
    end
  end

  assign dout = chain[DEPTH-1];

endmodule

// File: rtl/spi_display_receiver.sv
// SPI (mode 0, MSB first) receiver for a 16-bit display command stream.
// Each legal frame carries address [11:8] and data [7:0] into a small
// display register file (8 digits + mode registers).
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for cs_n to fall (or a fall seen during COMMIT)
// RECV   | shifting in mosi on sck rising edges until cs_n rises
// COMMIT | one-cycle settle after frame end; pulses are already out
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   sck, cs_n, mosi     : SPI pins, asynchronous to clk
//   word_valid, frame_err : one-cycle result pulses
//   word_addr, word_data  : fields of the last legal frame
//   shutdown_n, decode_mode, intensity, scan_limit, display_test : mode regs
//   rd_sel, rd_data     : combinational read of digit register rd_sel+1
//   busy                : synchronized cs_n is low
module spi_display_receiver
  import spi_display_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       word_valid,
  output logic [3:0] word_addr,
  output logic [7:0] word_data,
  output logic       frame_err,
  output logic       shutdown_n,
  output logic [7:0] decode_mode,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       display_test,
  input  logic [2:0] rd_sel,
  output logic [7:0] rd_data,
  output logic       busy
);

  logic sck_s, sck_h, cs_s, cs_h, mosi_s, mosi_h;

  spi_input_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .din(sck), .dout(sck_s), .dout_prev(sck_h)
  );
  spi_input_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(cs_n), .dout(cs_s), .dout_prev(cs_h)
  );
  spi_input_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi), .dout(mosi_s), .dout_prev(mosi_h)
  );

  logic sck_rise, cs_fall, cs_rise;
  assign sck_rise = sck_s & ~sck_h;
  assign cs_fall  = ~cs_s & cs_h;
  assign cs_rise  = cs_s & ~cs_h;

  logic [1:0]  state;
  logic [15:0] shreg;
  logic [4:0]  bit_cnt;
  logic        fall_pend;
  logic [7:0]  digit [8];

  logic [3:0] f_addr;
  logic [7:0] f_data;
  logic [3:0] digit_idx;
  assign f_addr    = shreg[11:8];
  assign f_data    = shreg[7:0];
  assign digit_idx = f_addr - 4'd1;

  // Frame bits [15:12] and the mosi history bit carry no information here.
  logic frame_unused;
  assign frame_unused = ^{shreg[15:12], digit_idx[3], mosi_h};

  // Commit actions are taken on the RECV->COMMIT edge so the pulse appears
  // SYNC_STAGES+1 edges after cs_n rises; COMMIT itself is a settle cycle
  // that also remembers a cs_n fall arriving on a short inter-frame gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      fall_pend    <= 1'b0;
      word_valid   <= 1'b0;
      frame_err    <= 1'b0;
      word_addr    <= '0;
      word_data    <= '0;
      for (int i = 0; i < 8; i++) digit[i] <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown_n   <= 1'b0;
      display_test <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall || fall_pend) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            fall_pend <= 1'b0;
            state     <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (cs_rise) begin
            state <= ST_COMMIT;
            if (bit_cnt == FRAME_BITS) begin
              word_valid <= 1'b1;
              word_addr  <= f_addr;
              word_data  <= f_data;
              if (f_addr >= ADDR_DIGIT0 && f_addr <= ADDR_DIGIT7) begin
                digit[digit_idx[2:0]] <= f_data;
              end else begin
                case (f_addr)
                  ADDR_DECODE:     decode_mode  <= f_data;
                  ADDR_INTENSITY:  intensity    <= f_data[3:0];
                  ADDR_SCAN_LIMIT: scan_limit   <= f_data[2:0];
                  ADDR_SHUTDOWN:   shutdown_n   <= f_data[0];
                  ADDR_TEST:       display_test <= f_data[0];
                  ADDR_NOOP:       ;
                  default:         ;
                endcase
              end
            end else if (bit_cnt != 5'd0) begin
              frame_err <= 1'b1;
            end
          end else if (sck_rise) begin
            shreg <= {shreg[14:0], mosi_s};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
          if (cs_fall) fall_pend <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rd_data = digit[rd_sel];
  assign busy    = ~cs_s;

endmodule

// File: tb/tb_spi_display_receiver.sv
module tb_spi_display_receiver;

  logic       clk, rst_n, sck, cs_n, mosi;
  logic       word_valid, frame_err, shutdown_n, display_test, busy;
  logic [3:0] word_addr, intensity;
  logic [7:0] word_data, decode_mode, rd_data;
  logic [2:0] scan_limit, rd_sel;

  spi_display_receiver #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .word_valid(word_valid), .word_addr(word_addr), .word_data(word_data),
    .frame_err(frame_err), .shutdown_n(shutdown_n), .decode_mode(decode_mode),
    .intensity(intensity), .scan_limit(scan_limit), .display_test(display_test),
    .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Observed pulse counts
  int n_valid = 0, n_err = 0, n_overlap = 0;
  always @(negedge clk) begin
    if (word_valid) n_valid++;
    if (frame_err) n_err++;
    if (word_valid && frame_err) n_overlap++;
  end

  // Reference model of the display register file
  logic [7:0] m_digit [8];
  logic [7:0] m_decode, m_data;
  logic [3:0] m_intensity, m_addr;
  logic [2:0] m_scan;
  logic       m_shutdown_n, m_test;
  int         m_valid = 0, m_err = 0;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
    m_decode = 0; m_intensity = 0; m_scan = 0; m_shutdown_n = 0; m_test = 0;
    m_addr = 0; m_data = 0;
  endtask

  task automatic model_commit(input logic [63:0] v, input int n);
    int a;
    if (n == 16) begin
      a = int'(v[11:8]);
      m_addr = v[11:8];
      m_data = v[7:0];
      m_valid++;
      if (a >= 1 && a <= 8) m_digit[a-1] = v[7:0];
      else if (a == 9)  m_decode = v[7:0];
      else if (a == 10) m_intensity = v[3:0];
      else if (a == 11) m_scan = v[2:0];
      else if (a == 12) m_shutdown_n = v[0];
      else if (a == 15) m_test = v[0];
    end else if (n != 0) begin
      m_err++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      wait_clk(4);
      sck = 1'b1;
      wait_clk(4);
      sck = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [63:0] v, input int n, input int gap);
    cs_n = 1'b0;
    wait_clk(4);
    shift_bits(v, n);
    wait_clk(4);
    model_commit(v, n);
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("latency_valid", {31'd0, word_valid}, {31'd0, n == 16});
    chk("latency_err", {31'd0, frame_err}, {31'd0, n != 16 && n != 0});
    wait_clk(gap);
  endtask

  task automatic check_all(input string tag);
    wait_clk(8);
    chk({tag, ".word_addr"}, {28'd0, word_addr}, {28'd0, m_addr});
    chk({tag, ".word_data"}, {24'd0, word_data}, {24'd0, m_data});
    chk({tag, ".decode_mode"}, {24'd0, decode_mode}, {24'd0, m_decode});
    chk({tag, ".intensity"}, {28'd0, intensity}, {28'd0, m_intensity});
    chk({tag, ".scan_limit"}, {29'd0, scan_limit}, {29'd0, m_scan});
    chk({tag, ".shutdown_n"}, {31'd0, shutdown_n}, {31'd0, m_shutdown_n});
    chk({tag, ".display_test"}, {31'd0, display_test}, {31'd0, m_test});
    chk({tag, ".valid_count"}, n_valid, m_valid);
    chk({tag, ".err_count"}, n_err, m_err);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      chk($sformatf("%s.rd_data%0d", tag, i), {24'd0, rd_data}, {24'd0, m_digit[i]});
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, n, gap;
    logic [63:0] v;
    sck = 0; cs_n = 1; mosi = 0; rd_sel = 0; rst_n = 0;
    model_reset();
    wait_clk(5);
    chk("reset.word_valid", {31'd0, word_valid}, 32'd0);
    chk("reset.frame_err", {31'd0, frame_err}, 32'd0);
    check_all("reset");
    rst_n = 1;
    wait_clk(5);

    // Single shutdown write, plus busy while selected
    cs_n = 1'b0;
    wait_clk(6);
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    cs_n = 1'b1;
    wait_clk(6);
    send_frame(64'h0C01, 16, 4);
    check_all("shutdown");

    // Back-to-back frames with a short gap
    send_frame(64'h09FF, 16, 1);
    send_frame(64'h0105, 16, 1);
    send_frame(64'h0687, 16, 1);
    check_all("b2b");

    // Truncated, overlong and counter-wrapping frames
    send_frame(64'h0A0F >> 1, 15, 4);
    check_all("short15");
    send_frame(64'h0A0F, 17, 4);
    check_all("long17");
    send_frame(64'h0A0F, 48, 4);
    check_all("long48");
    send_frame(64'h0, 0, 4);
    check_all("empty");

    // SCK activity while deselected is ignored
    shift_bits({$urandom, $urandom}, 20);
    check_all("sck_idle");
    send_frame(64'h0B07, 16, 4);
    check_all("scan");

    // Reset in the middle of a frame
    cs_n = 1'b0;
    wait_clk(4);
    shift_bits(64'h0C01 >> 8, 8);
    rst_n = 1'b0;
    wait_clk(2);
    cs_n = 1'b1;
    sck = 1'b0;
    model_reset();
    check_all("mid_reset");
    rst_n = 1'b1;
    wait_clk(6);
    check_all("post_reset");
    send_frame(64'h0C01, 16, 4);
    check_all("after_reset_frame");

    // Randomized frames against the model
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) n = 16;
      else if (r == 7) n = 0;
      else n = int'($urandom_range(1, 20));
      v = {$urandom, $urandom};
      gap = int'($urandom_range(1, 6));
      send_frame(v, n, gap);
      if (k % 4 == 3) check_all($sformatf("rand%0d", k));
    end
    check_all("rand_end");
    chk("valid_err_overlap", n_overlap, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
